// File: rtl/stack_top_param.sv
// Button-driven parametrised LIFO: two debounced buttons feed a register-array stack
// with occupancy, live top view, replace-top on simultaneous push+pop, sticky error flags.
module stack_debounce #(
  parameter int DB_CYCLES = 2000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic tick
);
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          sync_p0;
  logic          sync_p1;
  logic          level;
  logic          level_prev;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0    <= 1'b0;
      sync_p1    <= 1'b0;
      level      <= 1'b0;
      level_prev <= 1'b0;
      cnt        <= '0;
    end else begin
      sync_p0    <= raw;
      sync_p1    <= sync_p0;
      level_prev <= level;
      // level follows the synchronised input only after DB_CYCLES differing edges in a row
      if (sync_p1 != level) begin
        if (cnt == CW'(DB_CYCLES - 1)) begin
          level <= sync_p1;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign tick = level & ~level_prev;
endmodule

module stack_top_param #(
  parameter int DATA_SIZE      = 3,
  parameter int ADDR_SPACE_EXP = 2,
  parameter int DB_CYCLES      = 2000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic [DATA_SIZE-1:0]      push_data_in,
  input  logic                      err_clr,
  output logic [DATA_SIZE-1:0]      pop_data_out,
  output logic [DATA_SIZE-1:0]      top_data,
  output logic [ADDR_SPACE_EXP:0]   count,
  output logic                      empty,
  output logic                      full,
  output logic                      overflow,
  output logic                      underflow
);
  localparam int AW    = ADDR_SPACE_EXP;
  localparam int CNT_W = ADDR_SPACE_EXP + 1;
  localparam int DEPTH = 1 << ADDR_SPACE_EXP;

  logic                 push_tick;
  logic                 pop_tick;
  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_idx;
  logic [AW-1:0]        top_idx;
  logic [AW-1:0]        wr_addr;
  logic                 wr_en;
  logic                 rd_en;
  logic                 set_ov;
  logic                 set_un;
  logic [CNT_W-1:0]     cnt_next;

  stack_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_push (
    .clk(clk), .reset(reset), .raw(push), .tick(push_tick)
  );
  stack_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pop (
    .clk(clk), .reset(reset), .raw(pop), .tick(pop_tick)
  );

  // Low address bits double as the next free slot; top is one below (wraps correctly when full)
  assign wr_idx   = count[AW-1:0];
  assign top_idx  = wr_idx - 1'b1;
  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign top_data = empty ? '0 : mem[top_idx];

  always_comb begin
    wr_en    = 1'b0;
    wr_addr  = wr_idx;
    rd_en    = 1'b0;
    cnt_next = count;
    set_ov   = 1'b0;
    set_un   = 1'b0;
    case ({push_tick, pop_tick})
      2'b10: begin
        if (full) begin
          set_ov = 1'b1;
        end else begin
          wr_en    = 1'b1;
          cnt_next = count + 1'b1;
        end
      end
      2'b01: begin
        if (empty) begin
          set_un = 1'b1;
        end else begin
          rd_en    = 1'b1;
          cnt_next = count - 1'b1;
        end
      end
      2'b11: begin
        // Replace-top on a non-empty stack; an empty stack degrades to a plain push
        if (empty) begin
          wr_en    = 1'b1;
          cnt_next = count + 1'b1;
          set_un   = 1'b1;
        end else begin
          rd_en   = 1'b1;
          wr_en   = 1'b1;
          wr_addr = top_idx;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= push_data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count        <= '0;
      pop_data_out <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      count <= cnt_next;
      if (rd_en) pop_data_out <= mem[top_idx];
      // A new error event outranks a simultaneous clear
      overflow  <= set_ov | (overflow & ~err_clr);
      underflow <= set_un | (underflow & ~err_clr);
    end
  end
endmodule

// File: tb/tb_stack_top_param.sv
// Directed bench for stack_top_param with DATA_SIZE=3, ADDR_SPACE_EXP=2, DB_CYCLES=4.
module tb_stack_top_param;
  logic       clk = 1'b0;
  logic       reset;
  logic       push;
  logic       pop;
  logic [2:0] push_data_in;
  logic       err_clr;
  logic [2:0] pop_data_out;
  logic [2:0] top_data;
  logic [2:0] count;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       underflow;

  int vectors = 0;
  int miscompares = 0;

  stack_top_param #(.DATA_SIZE(3), .ADDR_SPACE_EXP(2), .DB_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .push_data_in(push_data_in),
    .err_clr(err_clr), .pop_data_out(pop_data_out), .top_data(top_data), .count(count),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Raise the raw buttons before edge 0; the stack updates on edge 6 (DB_CYCLES+2)
  task automatic press(input logic p, input logic q, input logic [2:0] d);
    @(negedge clk);
    push = p;
    pop = q;
    push_data_in = d;
    repeat (7) @(posedge clk);
    #1;
  endtask

  task automatic release_btns();
    @(negedge clk);
    push = 1'b0;
    pop = 1'b0;
    repeat (8) @(posedge clk);
  endtask

  task automatic clear_errors();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    push = 1'b0;
    pop = 1'b0;
    push_data_in = 3'd0;
    err_clr = 1'b0;

    // Reset with bouncing push
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      push = ~push;
    end
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_pop_data", 32'(pop_data_out), 32'd0);
    chk("rst_top", 32'(top_data), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);

    @(negedge clk);
    reset = 1'b0;
    push = 1'b0;
    push_data_in = 3'd1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      push = ~push;
    end
    @(negedge clk);
    chk("bounce_no_tick", 32'(count), 32'd0);
    push = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("db_edge5_count", 32'(count), 32'd0);
    @(posedge clk);
    #1;
    chk("db_edge6_count", 32'(count), 32'd1);
    chk("db_edge6_top", 32'(top_data), 32'd1);
    release_btns();

    // Fill and overflow
    press(1'b1, 1'b0, 3'd2);
    chk("fill2_count", 32'(count), 32'd2);
    chk("fill2_top", 32'(top_data), 32'd2);
    release_btns();
    press(1'b1, 1'b0, 3'd3);
    chk("fill3_count", 32'(count), 32'd3);
    chk("fill3_full", 32'(full), 32'd0);
    release_btns();
    press(1'b1, 1'b0, 3'd4);
    chk("fill4_count", 32'(count), 32'd4);
    chk("fill4_full", 32'(full), 32'd1);
    chk("fill4_top", 32'(top_data), 32'd4);
    release_btns();
    press(1'b1, 1'b0, 3'd5);
    chk("ovf_count", 32'(count), 32'd4);
    chk("ovf_top", 32'(top_data), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    release_btns();
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // err_clr held while another overflow happens: the set wins
    press(1'b1, 1'b0, 3'd6);
    chk("prio_overflow", 32'(overflow), 32'd1);
    chk("prio_count", 32'(count), 32'd4);
    @(negedge clk);
    err_clr = 1'b0;
    release_btns();
    chk("prio_sticky", 32'(overflow), 32'd1);
    clear_errors();
    #1;
    chk("prio_cleared", 32'(overflow), 32'd0);

    // Drain and underflow
    for (int i = 0; i < 4; i++) begin
      press(1'b0, 1'b1, 3'd0);
      chk("drain_pop_data", 32'(pop_data_out), 32'(4 - i));
      chk("drain_count", 32'(count), 32'(3 - i));
      release_btns();
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_top", 32'(top_data), 32'd0);
    press(1'b0, 1'b1, 3'd0);
    chk("unf_flag", 32'(underflow), 32'd1);
    chk("unf_pop_data", 32'(pop_data_out), 32'd1);
    chk("unf_count", 32'(count), 32'd0);
    release_btns();
    clear_errors();
    #1;
    chk("unf_cleared", 32'(underflow), 32'd0);

    // Simultaneous push+pop
    press(1'b1, 1'b0, 3'd1);
    release_btns();
    press(1'b1, 1'b0, 3'd2);
    release_btns();
    press(1'b1, 1'b1, 3'd7);
    chk("repl_pop_data", 32'(pop_data_out), 32'd2);
    chk("repl_top", 32'(top_data), 32'd7);
    chk("repl_count", 32'(count), 32'd2);
    chk("repl_no_unf", 32'(underflow), 32'd0);
    release_btns();
    press(1'b0, 1'b1, 3'd0);
    chk("repl_pop7", 32'(pop_data_out), 32'd7);
    release_btns();
    press(1'b0, 1'b1, 3'd0);
    chk("repl_pop1", 32'(pop_data_out), 32'd1);
    release_btns();
    press(1'b1, 1'b1, 3'd7);
    chk("both_empty_count", 32'(count), 32'd1);
    chk("both_empty_top", 32'(top_data), 32'd7);
    chk("both_empty_unf", 32'(underflow), 32'd1);
    chk("both_empty_pop_data", 32'(pop_data_out), 32'd1);
    release_btns();

    // Reset mid-operation with three entries and a press in flight
    press(1'b1, 1'b0, 3'd2);
    release_btns();
    press(1'b1, 1'b0, 3'd3);
    release_btns();
    chk("pre_rst_count", 32'(count), 32'd3);
    @(negedge clk);
    push = 1'b1;
    push_data_in = 3'd5;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_top", 32'(top_data), 32'd0);
    chk("mid_rst_pop_data", 32'(pop_data_out), 32'd0);
    chk("mid_rst_underflow", 32'(underflow), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_edge5", 32'(count), 32'd0);
    @(posedge clk);
    #1;
    chk("post_rst_edge6", 32'(count), 32'd1);
    chk("post_rst_top", 32'(top_data), 32'd5);
    release_btns();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
